bundle_fetch: RTL
=================

BUNDLE_FETCH -- requirements
Module: bundle_fetch

Interface
REQ-001 Parameters SHALL be: RESET_PC, default 32'h0000_0000, PC loaded on reset; NOP_INST, default 32'h0000_0013, slot filler for bubbles.
REQ-002 Clocking SHALL be one clock, with synchronous, active-high reset.
REQ-003 Ports SHALL be, in order:
- clk  in  1  clock.
- rst  in  1  sync reset, active-high.
- stall  in  1  hazard-unit hold.
- branch_taken  in  1  branch-unit redirect request.
- branch_target  in  32  redirect address.
- pc_out  out  32  fetch address to main_memory pc_in.
- inst_bundle_in  in  128  bundle from main_memory, same cycle as pc_out.
- ixu1_inst  out  32  slot 0.
- lsu_inst  out  32  slot 1.
- ixu2_inst  out  32  slot 2.
- branch_inst  out  32  slot 3.
- bundle_valid  out  1  IR holds a real bundle.
- bundle_pc  out  32  PC of the IR bundle.
- branch_squash  out  1  registered one-cycle squash to downstream units.
- fetch_fault  out  1  misaligned-redirect fault, sticky.
- perf_bundles  out  32  bundles issued.
- perf_bubbles  out  32  bubble cycles.

Function
REQ-004 Slot mapping SHALL be: [31:0] IXU1, [63:32] LSU, [95:64] IXU2, [127:96] BRANCH.
REQ-005 pc_out SHALL equal the PC register combinationally; the IR SHALL capture inst_bundle_in at the next rising edge, giving 1-cycle fetch latency.
REQ-006 The FSM SHALL have two states, RUN and HALT; RUN SHALL be entered on reset.
REQ-007 In RUN with no stall and no branch_taken, each edge SHALL do: IR<=inst_bundle_in, bundle_pc<=pc, bundle_valid<=1, pc<=pc+16.
REQ-008 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFF0+16 SHALL wrap to 32'h0.
REQ-009 In RUN with stall=1 and branch_taken=0, pc, IR, bundle_pc and bundle_valid SHALL hold.
REQ-010 branch_taken=1 with branch_target[3:0]==0 SHALL win over stall: pc<=branch_target, all slots<=NOP_INST, bundle_valid<=0, branch_squash<=1 for exactly one cycle.
REQ-011 branch_taken=1 with branch_target[3:0]!=0 SHALL cause: state<=HALT, fetch_fault<=1, slots<=NOP_INST, bundle_valid<=0, pc held.
REQ-012 In HALT, pc SHALL hold; all slots SHALL read NOP_INST; bundle_valid SHALL be 0; stall and branch_taken SHALL be ignored until rst.
REQ-013 When bundle_valid=0, each slot output SHALL be NOP_INST, regardless of stored data.

Reset
REQ-014 When rst=1 at an edge: pc<=RESET_PC, slots<=NOP_INST, bundle_valid<=0, bundle_pc<=RESET_PC, branch_squash<=0, fetch_fault<=0, state<=RUN, and perf counters SHALL clear.
REQ-015 rst SHALL override stall and branch_taken on the same edge, including when asserted mid-stall or in HALT.

Configuration
REQ-016 With FETCH_PERF_CNT_EN defined: perf_bundles SHALL increment on each REQ-007 load; perf_bubbles SHALL increment on each edge in RUN with stall or branch_taken; both SHALL saturate at 32'hFFFF_FFFF.
REQ-017 Without FETCH_PERF_CNT_EN: counter logic SHALL be absent, and perf_bundles and perf_bubbles SHALL be tied to 32'h0.

Structure
REQ-018 Shared vliw_pkg SHALL hold BUNDLE_W=128, INST_W=32, the slot index constants, the NOP constant, the PC increment (16) and the fetch_state_t enum {RUN, HALT}.
REQ-019 Counters SHALL live in sub-module fetch_perf_cnt, instantiated only under FETCH_PERF_CNT_EN; everything else SHALL stay flat.

Verification
REQ-020 Reset then 3 free-running cycles -> pc_out steps 0x0, 0x10, 0x20, 0x30; bundle_pc lags by one; bundle_valid=1 from the 2nd edge.
REQ-021 Bundle 0x...AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1111_2222 -> ixu1_inst=0x1111_2222, lsu_inst=0xEEEE_FFFF, ixu2_inst=0xCCCC_DDDD, branch_inst=0xAAAA_BBBB.
REQ-022 stall=1 for 2 cycles at pc=0x20 -> pc_out and all slots unchanged, perf_bubbles+=2 (macro on).
REQ-023 branch_taken=1 with stall=1, target=0x100 -> next cycle pc_out=0x100, slots=NOP_INST, branch_squash=1 for one cycle, then 0x110 follows.
REQ-024 branch_taken=1, target=0x104 -> fetch_fault=1, HALT, NOPs held; rst pulse -> pc_out=RESET_PC, fault cleared.
REQ-025 Set RESET_PC=32'hFFFF_FFE0, run 3 cycles -> pc_out 0xFFFF_FFE0, 0xFFFF_FFF0, 0x0000_0000.

Source files
------------

// File: rtl/vliw_pkg.sv
// Shared VLIW front-end constants: bundle geometry, slot indices, NOP filler,
// PC step and the fetch FSM state type.
package vliw_pkg;

  localparam int unsigned BUNDLE_W = 128;
  localparam int unsigned INST_W   = 32;

  localparam int unsigned SLOT_IXU1   = 0;
  localparam int unsigned SLOT_LSU    = 1;
  localparam int unsigned SLOT_IXU2   = 2;
  localparam int unsigned SLOT_BRANCH = 3;

  localparam logic [INST_W-1:0] NOP_INST_C = 32'h0000_0013;
  localparam logic [31:0]       PC_INC     = 32'd16;

  typedef enum logic {RUN, HALT} fetch_state_t;

  function automatic logic [INST_W-1:0] slot_of(input logic [BUNDLE_W-1:0] bundle,
                                                input int unsigned         idx);
    return bundle[idx*INST_W +: INST_W];
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating bundle/bubble event counters for the fetch stage.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        bundle_inc_i,
  input  logic        bubble_inc_i,
  output logic [31:0] perf_bundles_o,
  output logic [31:0] perf_bubbles_o
);

  logic [31:0] bundles_q, bundles_d;
  logic [31:0] bubbles_q, bubbles_d;

  always_comb begin
    bundles_d = bundles_q;
    bubbles_d = bubbles_q;
    if (bundle_inc_i && (bundles_q != '1)) bundles_d = bundles_q + 32'd1;
    if (bubble_inc_i && (bubbles_q != '1)) bubbles_d = bubbles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bundles_q <= '0;
      bubbles_q <= '0;
    end else begin
      bundles_q <= bundles_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign perf_bundles_o = bundles_q;
  assign perf_bubbles_o = bubbles_q;

endmodule

// File: rtl/bundle_fetch.sv
// VLIW bundle fetch stage: PC register, instruction register and RUN/HALT FSM.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
module bundle_fetch
  import vliw_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_C
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [31:0]         branch_target,
  output logic [31:0]         pc_out,
  input  logic [BUNDLE_W-1:0] inst_bundle_in,
  output logic [INST_W-1:0]   ixu1_inst,
  output logic [INST_W-1:0]   lsu_inst,
  output logic [INST_W-1:0]   ixu2_inst,
  output logic [INST_W-1:0]   branch_inst,
  output logic                bundle_valid,
  output logic [31:0]         bundle_pc,
  output logic                branch_squash,
  output logic                fetch_fault,
  output logic [31:0]         perf_bundles,
  output logic [31:0]         perf_bubbles
);

  fetch_state_t        state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [BUNDLE_W-1:0] ir_q, ir_d;
  logic [31:0]         bpc_q, bpc_d;
  logic                valid_q, valid_d;
  logic                squash_q, squash_d;
  logic                fault_q, fault_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    bpc_d    = bpc_q;
    valid_d  = valid_q;
    squash_d = 1'b0;
    fault_d  = fault_q;
    unique case (state_q)
      RUN: begin
        // A redirect outranks stall; a misaligned target parks the stage in HALT.
        if (branch_taken) begin
          ir_d    = {4{NOP_INST}};
          valid_d = 1'b0;
          if (branch_target[3:0] == 4'h0) begin
            pc_d     = branch_target;
            squash_d = 1'b1;
          end else begin
            state_d = HALT;
            fault_d = 1'b1;
          end
        end else if (!stall) begin
          ir_d    = inst_bundle_in;
          bpc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + PC_INC;
        end
      end
      HALT: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      ir_q     <= {4{NOP_INST}};
      bpc_q    <= RESET_PC;
      valid_q  <= 1'b0;
      squash_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      bpc_q    <= bpc_d;
      valid_q  <= valid_d;
      squash_q <= squash_d;
      fault_q  <= fault_d;
    end
  end

  assign pc_out        = pc_q;
  assign bundle_valid  = valid_q;
  assign bundle_pc     = bpc_q;
  assign branch_squash = squash_q;
  assign fetch_fault   = fault_q;

  assign ixu1_inst   = valid_q ? slot_of(ir_q, SLOT_IXU1)   : NOP_INST;
  assign lsu_inst    = valid_q ? slot_of(ir_q, SLOT_LSU)    : NOP_INST;
  assign ixu2_inst   = valid_q ? slot_of(ir_q, SLOT_IXU2)   : NOP_INST;
  assign branch_inst = valid_q ? slot_of(ir_q, SLOT_BRANCH) : NOP_INST;

`ifdef FETCH_PERF_CNT_EN
  logic bundle_inc, bubble_inc;
  assign bundle_inc = (state_q == RUN) && !branch_taken && !stall;
  assign bubble_inc = (state_q == RUN) && (branch_taken || stall);

  fetch_perf_cnt u_perf (
    .clk            (clk),
    .rst            (rst),
    .bundle_inc_i   (bundle_inc),
    .bubble_inc_i   (bubble_inc),
    .perf_bundles_o (perf_bundles),
    .perf_bubbles_o (perf_bubbles)
  );
`else
  assign perf_bundles = '0;
  assign perf_bubbles = '0;
`endif

endmodule
